offchip_mem_ctrl: RTL and testbench
===================================

Name: offchip_mem_ctrl

Overview:
- Off-chip memory controller directly downstream of cpu_pipeline's cache-line port (offchip_mem_*).
- Converts one cache-line read or write request into a burst of 32-bit beats on a narrow external SRAM-style bus with an ack handshake.
- For reads, assembles the beats into a full line and returns it with a one-cycle offchip_mem_ready pulse.
- For writes, splits the line into beats, then pulses offchip_mem_ready.

Parameters:
LINE_BYTES, 16, cache line size in bytes (equals `CACHE_LINE_SIZE); power of two, >= 4
ADDR_WIDTH, 32, byte address width

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
offchip_mem_read_en  input  1  line read request (level)
offchip_mem_write_en  input  1  line write request (level)
offchip_mem_addr  input  ADDR_WIDTH  line byte address
offchip_mem_wdata  input  LINE_BYTES*8  line write data
offchip_mem_data  output  LINE_BYTES*8  assembled read line
offchip_mem_ready  output  1  one-cycle completion pulse
busy  output  1  high from accept until return to IDLE
ext_req  output  1  external beat request
ext_we  output  1  external beat is a write
ext_addr  output  ADDR_WIDTH  external beat byte address
ext_wdata  output  32  external beat write data
ext_rdata  input  32  external beat read data, valid with ext_ack
ext_ack  input  1  beat complete, sampled at posedge clk while ext_req=1

Behaviour:
- Reset (rst=0, async): state=IDLE, beat counter=0. All outputs 0, including offchip_mem_data, ext_req and busy.
- Reset mid-burst: ext_req drops immediately and the partial line is discarded. After rst returns high, the controller ignores any request level that is still held high; a new request needs en low for at least one cycle (RELEASE rule).
- States: IDLE, RD_BEAT, WR_BEAT, DONE, RELEASE.
- IDLE: at a posedge with write_en=1, go to WR_BEAT. Otherwise, with read_en=1, go to RD_BEAT. Write wins if both are high.
  - On accept, latch base = addr with its low log2(LINE_BYTES) bits forced to 0.
  - On accept, latch wdata and clear the beat counter.
- RD_BEAT / WR_BEAT outputs:
  - ext_req=1.
  - ext_addr = base + 4*beat.
  - ext_we = 1 in WR_BEAT only.
  - ext_wdata = wdata[32*beat+31 : 32*beat].
  - All are registered outputs, stable while waiting for ack.
- Beat completion: at a posedge with ext_ack=1:
  - Reads capture ext_rdata into offchip_mem_data[32*beat+31 : 32*beat]; word 0 goes to the LSBs.
  - The beat counter increments.
  - The next beat is presented next cycle with ext_req kept high (back-to-back beats).
  - After beat LINE_BYTES/4-1, go to DONE.
- ext_ack while ext_req=0 is ignored.
- No timeout: ext_req holds indefinitely until acked.
- DONE: offchip_mem_ready=1 for exactly one cycle, then go to RELEASE.
- RELEASE: stay until read_en=0 and write_en=0 at a posedge, then go to IDLE. A level held after ready never retriggers.
- offchip_mem_data:
  - Updates only on read beats and holds its value across write requests and idle.
  - It is fully valid in the cycle ready is high and stays valid until the next read's first ack.
- busy=1 in RD_BEAT, WR_BEAT and DONE; busy=0 in IDLE and RELEASE.
- Latency: request accepted at edge N; beat 0 is presented in cycle N+1. With ack=1 every cycle, ready is high in cycle N+1+LINE_BYTES/4 (5 for 16 bytes).
- Address arithmetic is mod 2^ADDR_WIDTH. Beats never cross the line because of the alignment.

Test Plan:
- Reset: hold rst=0 while driving en and ack high.
  -> All outputs stay 0 and busy=0.
- Read, zero-wait: read_en=1, addr=0x0000_0000, ext_ack tied 1, ext_rdata returns 0x00000093, 0x00100113, 0x002081b3, 0x00000000.
  -> ext_addr sequence is 0x0, 0x4, 0x8, 0xC.
  -> ready pulses 5 cycles after accept with offchip_mem_data = 128'h00000000002081b30010011300000093.
  -> read_en held high afterwards causes no second burst.
- Read with wait states: ack asserted only on every third cycle of each beat, addr=0x0000_1238.
  -> Base is 0x1230; ext_addr sequence is 0x1230, 0x1234, 0x1238, 0x123C.
  -> ext_req and ext_addr stay stable during waits; ready comes 13 cycles after accept.
- Write: write_en=1, addr=0x40, wdata = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, ack=1.
  -> ext_we=1 with beats (0x40, AAAAAAAA), (0x44, BBBBBBBB), (0x48, CCCCCCCC), (0x4C, DDDDDDDD).
  -> ready pulses once and offchip_mem_data is unchanged.
- Simultaneous and back-to-back: read_en=write_en=1.
  -> The write burst runs.
  -> Then drop both for one cycle and raise read_en: a read burst starts with no ready overlap.
- Reset mid-burst: assert rst=0 after beat 1 ack of a read.
  -> ext_req falls without waiting for clk, offchip_mem_data=0, and no ready pulse occurs.
  -> After release with read_en still high, no burst occurs until read_en toggles low then high.

Source files
------------

// File: rtl/offchip_mem_ctrl_if.sv
// Cache-line request port and narrow external beat bus of offchip_mem_ctrl.
// The controller uses the slave view; the requester/memory side uses the master view.
interface offchip_mem_ctrl_if #(
  parameter int LINE_BYTES = 16,
  parameter int ADDR_WIDTH = 32
);
  logic                    offchip_mem_read_en;
  logic                    offchip_mem_write_en;
  logic [ADDR_WIDTH-1:0]   offchip_mem_addr;
  logic [LINE_BYTES*8-1:0] offchip_mem_wdata;
  logic [LINE_BYTES*8-1:0] offchip_mem_data;
  logic                    offchip_mem_ready;
  logic                    busy;
  logic                    ext_req;
  logic                    ext_we;
  logic [ADDR_WIDTH-1:0]   ext_addr;
  logic [31:0]             ext_wdata;
  logic [31:0]             ext_rdata;
  logic                    ext_ack;

  modport slave (
    input  offchip_mem_read_en, offchip_mem_write_en, offchip_mem_addr, offchip_mem_wdata,
    input  ext_rdata, ext_ack,
    output offchip_mem_data, offchip_mem_ready, busy,
    output ext_req, ext_we, ext_addr, ext_wdata
  );

  modport master (
    output offchip_mem_read_en, offchip_mem_write_en, offchip_mem_addr, offchip_mem_wdata,
    output ext_rdata, ext_ack,
    input  offchip_mem_data, offchip_mem_ready, busy,
    input  ext_req, ext_we, ext_addr, ext_wdata
  );
endinterface

// File: rtl/offchip_mem_ctrl.sv
// Off-chip memory controller: turns one cache-line read/write into a burst of
// 32-bit acked beats on an external SRAM-style bus, with a one-cycle ready pulse.
module offchip_mem_ctrl #(
  parameter int LINE_BYTES = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  offchip_mem_ctrl_if.slave  bus
);
  localparam int NBEATS = LINE_BYTES / 4;
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int LINE_W = LINE_BYTES * 8;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_BEAT = 3'd1,
    WR_BEAT = 3'd2,
    DONE    = 3'd3,
    RELEASE = 3'd4
  } state_e;

  function automatic logic [31:0] line_word(input logic [LINE_W-1:0] line,
                                            input logic [BEAT_W-1:0] idx);
    logic [31:0] w;
    w = 32'd0;
    for (int i = 0; i < NBEATS; i++) begin
      if (idx == BEAT_W'(i)) begin
        w = line[32*i +: 32];
      end
    end
    return w;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [ADDR_WIDTH-1:0] base,
                                                      input logic [BEAT_W-1:0]     idx);
    return base + ADDR_WIDTH'({idx, 2'b00});
  endfunction

  state_e                 state_q, state_d;
  logic [BEAT_W-1:0]      beat_q, beat_d, beat_nxt;
  logic [ADDR_WIDTH-1:0]  base_q, base_d, accept_base;
  logic [LINE_W-1:0]      wdata_q, wdata_d;
  logic [LINE_W-1:0]      data_q, data_d;
  logic                   armed_q, armed_d;
  logic                   ext_req_q, ext_req_d;
  logic                   ext_we_q, ext_we_d;
  logic [ADDR_WIDTH-1:0]  ext_addr_q, ext_addr_d;
  logic [31:0]            ext_wdata_q, ext_wdata_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;
  logic                   rd_s, wr_s, req_any;

  assign rd_s    = bus.offchip_mem_read_en;
  assign wr_s    = bus.offchip_mem_write_en;
  assign req_any = rd_s | wr_s;

  // Next-state and next-output logic; every output is registered from its _d value.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    data_d      = data_q;
    armed_d     = armed_q;
    ext_req_d   = ext_req_q;
    ext_we_d    = ext_we_q;
    ext_addr_d  = ext_addr_q;
    ext_wdata_d = ext_wdata_q;
    beat_nxt    = beat_q + BEAT_W'(1);
    accept_base = bus.offchip_mem_addr & ~ADDR_WIDTH'(LINE_BYTES - 1);

    case (state_q)
      IDLE: begin
        // armed_q is only set after a cycle with both enables low, so a level
        // still held across reset cannot start a burst.
        if (armed_q && req_any) begin
          state_d     = wr_s ? WR_BEAT : RD_BEAT;
          armed_d     = 1'b0;
          base_d      = accept_base;
          wdata_d     = bus.offchip_mem_wdata;
          beat_d      = '0;
          ext_req_d   = 1'b1;
          ext_we_d    = wr_s;
          ext_addr_d  = accept_base;
          ext_wdata_d = line_word(bus.offchip_mem_wdata, '0);
        end else begin
          armed_d = armed_q | ~req_any;
        end
      end
      RD_BEAT, WR_BEAT: begin
        if (bus.ext_ack) begin
          if (state_q == RD_BEAT) begin
            for (int i = 0; i < NBEATS; i++) begin
              if (beat_q == BEAT_W'(i)) begin
                data_d[32*i +: 32] = bus.ext_rdata;
              end
            end
          end else begin
            data_d = data_q;
          end
          if (beat_q == LAST_BEAT) begin
            state_d     = DONE;
            beat_d      = '0;
            ext_req_d   = 1'b0;
            ext_we_d    = 1'b0;
            ext_addr_d  = '0;
            ext_wdata_d = 32'd0;
          end else begin
            beat_d      = beat_nxt;
            ext_addr_d  = beat_addr(base_q, beat_nxt);
            ext_wdata_d = line_word(wdata_q, beat_nxt);
          end
        end else begin
          state_d = state_q;
        end
      end
      DONE: begin
        state_d = RELEASE;
      end
      RELEASE: begin
        if (!req_any) begin
          state_d = IDLE;
          armed_d = 1'b1;
        end else begin
          state_d = RELEASE;
        end
      end
      default: begin
        state_d     = IDLE;
        armed_d     = 1'b0;
        beat_d      = '0;
        ext_req_d   = 1'b0;
        ext_we_d    = 1'b0;
        ext_addr_d  = '0;
        ext_wdata_d = 32'd0;
      end
    endcase

    ready_d = (state_d == DONE);
    busy_d  = (state_d == RD_BEAT) || (state_d == WR_BEAT) || (state_d == DONE);
  end

  // State and output registers; reset drops ext_req and discards any partial line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      base_q      <= '0;
      wdata_q     <= '0;
      data_q      <= '0;
      armed_q     <= 1'b0;
      ext_req_q   <= 1'b0;
      ext_we_q    <= 1'b0;
      ext_addr_q  <= '0;
      ext_wdata_q <= 32'd0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      data_q      <= data_d;
      armed_q     <= armed_d;
      ext_req_q   <= ext_req_d;
      ext_we_q    <= ext_we_d;
      ext_addr_q  <= ext_addr_d;
      ext_wdata_q <= ext_wdata_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.offchip_mem_data  = data_q;
  assign bus.offchip_mem_ready = ready_q;
  assign bus.busy              = busy_q;
  assign bus.ext_req           = ext_req_q;
  assign bus.ext_we            = ext_we_q;
  assign bus.ext_addr          = ext_addr_q;
  assign bus.ext_wdata         = ext_wdata_q;
endmodule

// File: tb/tb_offchip_mem_ctrl.sv
// Self-checking bench for offchip_mem_ctrl: directed scenarios plus random traffic,
// compared every cycle against a transaction-level model of the controller.
module tb_offchip_mem_ctrl;
  localparam int LB = 16;
  localparam int AW = 32;
  localparam int NB = LB / 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  offchip_mem_ctrl_if #(.LINE_BYTES(LB), .ADDR_WIDTH(AW)) bus ();
  offchip_mem_ctrl #(.LINE_BYTES(LB), .ADDR_WIDTH(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  int rdy_cnt = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- external memory responder ----------------
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } beat_t;
  beat_t beat_log[$];
  logic [31:0] mem [logic [31:0]];
  int mode = 0;
  logic ack_force = 1'b0;
  int wcnt = 0;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0F69;
  endfunction

  initial begin
    bus.ext_ack   = 1'b0;
    bus.ext_rdata = 32'd0;
    forever begin
      @(negedge clk); #1;
      if (ack_force) begin
        bus.ext_ack = 1'b1;
      end else if (bus.ext_req) begin
        logic a;
        wcnt++;
        case (mode)
          0: a = 1'b1;
          1: a = (wcnt >= 3);
          default: a = ($urandom_range(0, 2) == 0);
        endcase
        bus.ext_ack = a;
        if (a) begin
          wcnt = 0;
          bus.ext_rdata = rd_word(bus.ext_addr);
          beat_log.push_back('{bus.ext_we, bus.ext_addr, bus.ext_wdata});
        end else begin
          bus.ext_rdata = $urandom;
        end
      end else begin
        wcnt = 0;
        bus.ext_ack = (mode == 2) ? ($urandom_range(0, 1) == 1) : 1'b0;
        bus.ext_rdata = $urandom;
      end
    end
  end

  // ---------------- transaction-level model ----------------
  int           m_kind = 0;      // 0 none, 1 read burst, 2 write burst
  int           m_beat = 0;
  logic         m_ready = 1'b0;
  logic         m_wait_low = 1'b1;
  logic [31:0]  m_base = 32'd0;
  logic [127:0] m_wline = '0;
  logic [127:0] m_data = '0;

  // A burst ends with one ready cycle; then both enables must be seen low before a new accept.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_kind <= 0; m_beat <= 0; m_ready <= 1'b0; m_wait_low <= 1'b1;
      m_base <= 32'd0; m_wline <= '0; m_data <= '0;
    end else if (m_ready) begin
      m_ready <= 1'b0;
    end else if (m_kind != 0) begin
      if (bus.ext_ack) begin
        if (m_kind == 1) m_data[32*m_beat +: 32] <= bus.ext_rdata;
        m_beat <= m_beat + 1;
        if (m_beat == NB - 1) begin
          m_kind <= 0; m_ready <= 1'b1; m_wait_low <= 1'b1;
        end
      end
    end else if (m_wait_low) begin
      if (!bus.offchip_mem_read_en && !bus.offchip_mem_write_en) m_wait_low <= 1'b0;
    end else if (bus.offchip_mem_read_en || bus.offchip_mem_write_en) begin
      m_kind  <= bus.offchip_mem_write_en ? 2 : 1;
      m_base  <= bus.offchip_mem_addr - (bus.offchip_mem_addr % LB);
      m_wline <= bus.offchip_mem_wdata;
      m_beat  <= 0;
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  initial begin
    forever begin
      logic [31:0] e_addr, e_wdata;
      @(negedge clk);
      e_addr = 32'd0; e_wdata = 32'd0;
      if (m_kind != 0) begin
        e_addr  = m_base + 32'(4 * m_beat);
        e_wdata = m_wline[32*m_beat +: 32];
      end
      check("ext_req",   bus.ext_req,   128'(m_kind != 0));
      check("ext_we",    bus.ext_we,    128'(m_kind == 2));
      check("ext_addr",  bus.ext_addr,  128'(e_addr));
      check("ext_wdata", bus.ext_wdata, 128'(e_wdata));
      check("ready",     bus.offchip_mem_ready, 128'(m_ready));
      check("busy",      bus.busy,      128'((m_kind != 0) || m_ready));
      check("line_data", bus.offchip_mem_data, m_data);
      if (bus.offchip_mem_ready === 1'b1) rdy_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic run_burst(output int lat);
    lat = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (bus.offchip_mem_ready === 1'b1) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL burst_timeout: got no ready, expected ready within 200 cycles");
    end
  endtask

  task automatic check_log(input string nm, input logic we, input logic [31:0] base,
                           input logic chk_data, input logic [127:0] line);
    check({nm, "_nbeats"}, 128'(beat_log.size()), 128'(NB));
    for (int i = 0; i < NB && i < beat_log.size(); i++) begin
      check({nm, "_we"},   128'(beat_log[i].we),   128'(we));
      check({nm, "_addr"}, 128'(beat_log[i].addr), 128'(base + 32'(4 * i)));
      if (chk_data) check({nm, "_wdata"}, 128'(beat_log[i].wdata), 128'(line[32*i +: 32]));
    end
  endtask

  initial begin
    int lat, r0, reqs;
    logic [127:0] rd_line, wline;

    bus.offchip_mem_read_en  = 1'b0;
    bus.offchip_mem_write_en = 1'b0;
    bus.offchip_mem_addr     = 32'd0;
    bus.offchip_mem_wdata    = '0;

    // Reset held with request and ack levels high.
    rst = 1'b0;
    bus.offchip_mem_read_en = 1'b1; bus.offchip_mem_write_en = 1'b1; ack_force = 1'b1;
    repeat (5) tick();
    check("rst_ext_req", bus.ext_req, 128'd0);
    check("rst_busy",    bus.busy,    128'd0);
    check("rst_data",    bus.offchip_mem_data, 128'd0);
    bus.offchip_mem_read_en = 1'b0; bus.offchip_mem_write_en = 1'b0; ack_force = 1'b0;
    tick();
    rst = 1'b1;
    repeat (2) tick();

    // Zero-wait read from address 0.
    mem[32'h0] = 32'h0000_0093; mem[32'h4] = 32'h0010_0113;
    mem[32'h8] = 32'h0020_81b3; mem[32'hC] = 32'h0000_0000;
    mode = 0; beat_log.delete();
    bus.offchip_mem_addr = 32'h0; bus.offchip_mem_read_en = 1'b1;
    run_burst(lat);
    check("rd0_latency", 128'(lat), 128'd5);
    check("rd0_data",  bus.offchip_mem_data, 128'h00000000_002081b3_00100113_00000093);
    check("rd0_model", m_data,               128'h00000000_002081b3_00100113_00000093);
    check_log("rd0", 1'b0, 32'h0, 1'b0, '0);
    reqs = 0; r0 = rdy_cnt;
    repeat (10) begin tick(); if (bus.ext_req) reqs++; end
    check("rd0_held_no_reburst", 128'(reqs), 128'd0);
    check("rd0_single_ready", 128'(rdy_cnt - r0), 128'd0);
    bus.offchip_mem_read_en = 1'b0;
    repeat (2) tick();

    // Read with two wait cycles per beat from an unaligned address.
    mode = 1; beat_log.delete();
    bus.offchip_mem_addr = 32'h0000_1238; bus.offchip_mem_read_en = 1'b1;
    run_burst(lat);
    check("rdw_latency", 128'(lat), 128'd13);
    check_log("rdw", 1'b0, 32'h0000_1230, 1'b0, '0);
    rd_line = {rd_word(32'h123C), rd_word(32'h1238), rd_word(32'h1234), rd_word(32'h1230)};
    check("rdw_data", bus.offchip_mem_data, rd_line);
    tick();
    bus.offchip_mem_read_en = 1'b0;
    repeat (2) tick();

    // Line write; read data register must keep the previous line.
    mode = 0; beat_log.delete(); r0 = rdy_cnt;
    bus.offchip_mem_addr  = 32'h40;
    bus.offchip_mem_wdata = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    bus.offchip_mem_write_en = 1'b1;
    run_burst(lat);
    check("wr_latency", 128'(lat), 128'd5);
    check_log("wr", 1'b1, 32'h40, 1'b1, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
    tick();
    bus.offchip_mem_write_en = 1'b0;
    repeat (3) tick();
    check("wr_ready_pulses", 128'(rdy_cnt - r0), 128'd1);
    check("wr_data_kept", bus.offchip_mem_data, rd_line);

    // Simultaneous request: write wins; then one low cycle and a read follows.
    beat_log.delete(); r0 = rdy_cnt;
    wline = {$urandom, $urandom, $urandom, $urandom};
    bus.offchip_mem_addr = 32'h0000_2000 | 32'($urandom_range(0, 15));
    bus.offchip_mem_wdata = wline;
    bus.offchip_mem_read_en = 1'b1; bus.offchip_mem_write_en = 1'b1;
    run_burst(lat);
    check("both_latency", 128'(lat), 128'd5);
    check_log("both", 1'b1, 32'h0000_2000, 1'b1, wline);
    repeat (2) tick();
    bus.offchip_mem_read_en = 1'b0; bus.offchip_mem_write_en = 1'b0;
    tick();
    beat_log.delete();
    bus.offchip_mem_read_en = 1'b1; bus.offchip_mem_addr = 32'hFFFF_FFF4;
    run_burst(lat);
    check("b2b_rd_latency", 128'(lat), 128'd5);
    check_log("b2b_rd", 1'b0, 32'hFFFF_FFF0, 1'b0, '0);
    tick();
    bus.offchip_mem_read_en = 1'b0;
    repeat (3) tick();
    check("b2b_ready_pulses", 128'(rdy_cnt - r0), 128'd2);

    // Reset in the middle of a read burst.
    beat_log.delete(); r0 = rdy_cnt;
    bus.offchip_mem_addr = 32'h0000_3000; bus.offchip_mem_read_en = 1'b1;
    for (int k = 0; k < 100 && beat_log.size() < 2; k++) begin
      @(negedge clk); #2;
    end
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("mid_rst_req_async", bus.ext_req, 128'd0);
    check("mid_rst_data",      bus.offchip_mem_data, 128'd0);
    check("mid_rst_busy",      bus.busy, 128'd0);
    repeat (2) tick();
    rst = 1'b1;
    reqs = 0;
    repeat (8) begin tick(); if (bus.ext_req) reqs++; end
    check("post_rst_held_no_burst", 128'(reqs), 128'd0);
    check("mid_rst_no_ready", 128'(rdy_cnt - r0), 128'd0);
    bus.offchip_mem_read_en = 1'b0;
    tick();
    bus.offchip_mem_read_en = 1'b1;
    run_burst(lat);
    check("post_rst_toggle_latency", 128'(lat), 128'd5);
    tick();
    bus.offchip_mem_read_en = 1'b0;
    repeat (2) tick();

    // Random levels, addresses, data, ack timing and occasional resets.
    mode = 2;
    for (int i = 0; i < 600; i++) begin
      tick();
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b0;
        tick();
        rst = 1'b1;
      end
      bus.offchip_mem_read_en  = ($urandom_range(0, 2) == 0);
      bus.offchip_mem_write_en = ($urandom_range(0, 3) == 0);
      bus.offchip_mem_addr     = $urandom;
      bus.offchip_mem_wdata    = {$urandom, $urandom, $urandom, $urandom};
    end
    bus.offchip_mem_read_en = 1'b0; bus.offchip_mem_write_en = 1'b0;
    mode = 0;
    repeat (20) tick();
    check("final_idle_busy", bus.busy, 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
